// File: rtl/seq_ctrl_unit.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/HALT with a req/ready memory handshake and timeout.
// Optional retired-instruction counter enabled by defining SEQ_CTRL_PERF_CNT_EN.
module seq_ctrl_unit #(
    parameter int INST_W      = 32,
    parameter int OPC_W       = 4,
    parameter int FUNC_W      = 4,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              run_i,
    input  logic [INST_W-1:0] inst_i,
    input  logic              status_c_i,
    input  logic              status_z_i,
    input  logic              mem_ready_i,
    output logic [3:0]        phase_o,
    output logic              ld_ir_o,
    output logic              inc_pc_o,
    output logic              ld_pc_o,
    output logic              ld_a_o,
    output logic              ld_b_o,
    output logic              ld_c_o,
    output logic              ld_z_o,
    output logic              clr_a_o,
    output logic              clr_b_o,
    output logic              clr_c_o,
    output logic              clr_z_o,
    output logic              a_mux_o,
    output logic              b_mux_o,
    output logic              im_mux1_o,
    output logic              reg_mux_o,
    output logic [1:0]        im_mux2_o,
    output logic [1:0]        data_mux_o,
    output logic [2:0]        alu_op_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic              mem_err_o,
    output logic              halted_o
`ifdef SEQ_CTRL_PERF_CNT_EN
    ,
    output logic [31:0]       retired_o
`endif
);

    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    localparam logic [OPC_W-1:0] OP_LDAI = OPC_W'(4'h0);
    localparam logic [OPC_W-1:0] OP_LDBI = OPC_W'(4'h1);
    localparam logic [OPC_W-1:0] OP_STA  = OPC_W'(4'h2);
    localparam logic [OPC_W-1:0] OP_STB  = OPC_W'(4'h3);
    localparam logic [OPC_W-1:0] OP_LUI  = OPC_W'(4'h4);
    localparam logic [OPC_W-1:0] OP_JMP  = OPC_W'(4'h5);
    localparam logic [OPC_W-1:0] OP_BEQ  = OPC_W'(4'h6);
    localparam logic [OPC_W-1:0] OP_ALU  = OPC_W'(4'h7);
    localparam logic [OPC_W-1:0] OP_BNE  = OPC_W'(4'h8);
    localparam logic [OPC_W-1:0] OP_LDA  = OPC_W'(4'h9);
    localparam logic [OPC_W-1:0] OP_LDB  = OPC_W'(4'hA);
    localparam logic [OPC_W-1:0] OP_HALT = OPC_W'(4'hF);

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;
    localparam logic [2:0] ALU_ROL = 3'b100;
    localparam logic [2:0] ALU_ROR = 3'b101;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_HALT   = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_err_q, mem_err_d;

    logic [OPC_W-1:0]  opc;
    logic [FUNC_W-1:0] func;
    logic              is_mem_op, is_load, arith;
    logic              unused_inst;

    assign opc         = inst_i[INST_W-1 -: OPC_W];
    assign func        = inst_i[INST_W-OPC_W-1 -: FUNC_W];
    assign unused_inst = ^inst_i;
    assign is_load     = (opc == OP_LDA) || (opc == OP_LDB);
    assign is_mem_op   = is_load || (opc == OP_STA) || (opc == OP_STB);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_FETCH;
            cnt_q     <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mem_err_q <= mem_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mem_err_d  = mem_err_q;
        arith      = 1'b0;
        ld_ir_o    = 1'b0;
        inc_pc_o   = 1'b0;
        ld_pc_o    = 1'b0;
        ld_a_o     = 1'b0;
        ld_b_o     = 1'b0;
        ld_c_o     = 1'b0;
        ld_z_o     = 1'b0;
        clr_a_o    = 1'b0;
        clr_b_o    = 1'b0;
        clr_c_o    = 1'b0;
        clr_z_o    = 1'b0;
        a_mux_o    = 1'b0;
        b_mux_o    = 1'b0;
        im_mux1_o  = 1'b0;
        reg_mux_o  = 1'b0;
        im_mux2_o  = 2'b00;
        data_mux_o = 2'b00;
        alu_op_o   = 3'b000;
        mem_req_o  = 1'b0;
        mem_we_o   = 1'b0;

        // run=0 freezes state/counter and silences every strobe, including mem_req.
        if (run_i && !rst_i) begin
            case (state_q)
                S_FETCH: begin
                    ld_ir_o = 1'b1;
                    state_d = S_DECODE;
                end
                S_DECODE: begin
                    inc_pc_o = 1'b1;
                    ld_pc_o  = 1'b1;
                    state_d  = S_EXEC;
                end
                S_EXEC: begin
                    cnt_d = '0;
                    case (opc)
                        OP_LDAI: ld_a_o = 1'b1;
                        OP_LDBI: begin
                            ld_b_o  = 1'b1;
                            b_mux_o = 1'b1;
                        end
                        OP_LUI: begin
                            im_mux1_o  = 1'b1;
                            data_mux_o = 2'b01;
                            alu_op_o   = ALU_ADD;
                            ld_a_o     = 1'b1;
                            ld_c_o     = 1'b1;
                            ld_z_o     = 1'b1;
                        end
                        OP_JMP: ld_pc_o = 1'b1;
                        OP_BEQ: ld_pc_o = status_z_i;
                        OP_BNE: ld_pc_o = !status_z_i;
                        OP_ALU: begin
                            case (func)
                                FUNC_W'(4'h0): begin arith = 1'b1; alu_op_o = ALU_ADD; end
                                FUNC_W'(4'h1): begin arith = 1'b1; alu_op_o = ALU_ADD; im_mux2_o = 2'b01; end
                                FUNC_W'(4'h2): begin arith = 1'b1; alu_op_o = ALU_SUB; end
                                FUNC_W'(4'h3): begin arith = 1'b1; alu_op_o = ALU_ADD; im_mux2_o = 2'b10; end
                                FUNC_W'(4'h4): begin arith = 1'b1; alu_op_o = ALU_ROL; end
                                FUNC_W'(4'h5): clr_a_o = 1'b1;
                                FUNC_W'(4'h6): clr_b_o = 1'b1;
                                FUNC_W'(4'h7): clr_c_o = 1'b1;
                                FUNC_W'(4'h8): clr_z_o = 1'b1;
                                FUNC_W'(4'h9): begin arith = 1'b1; alu_op_o = ALU_AND; im_mux2_o = 2'b01; end
                                FUNC_W'(4'hA): begin inc_pc_o = status_z_i; ld_pc_o = status_z_i; end
                                FUNC_W'(4'hB): begin arith = 1'b1; alu_op_o = ALU_AND; end
                                FUNC_W'(4'hC): begin inc_pc_o = status_c_i; ld_pc_o = status_c_i; end
                                FUNC_W'(4'hD): begin arith = 1'b1; alu_op_o = ALU_OR; im_mux2_o = 2'b01; end
                                FUNC_W'(4'hE): begin arith = 1'b1; alu_op_o = ALU_SUB; im_mux2_o = 2'b10; end
                                FUNC_W'(4'hF): begin arith = 1'b1; alu_op_o = ALU_ROR; end
                                default: ;
                            endcase
                            if (arith) begin
                                data_mux_o = 2'b10;
                                ld_a_o     = 1'b1;
                                ld_c_o     = 1'b1;
                                ld_z_o     = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                    if (is_mem_op)
                        state_d = S_MEM;
                    else if (opc == OP_HALT)
                        state_d = S_HALT;
                    else
                        state_d = S_FETCH;
                end
                S_MEM: begin
                    mem_req_o = 1'b1;
                    mem_we_o  = (opc == OP_STA) || (opc == OP_STB);
                    reg_mux_o = (opc == OP_STB) || (opc == OP_LDB);
                    if (is_load)
                        data_mux_o = 2'b01;
                    if (mem_ready_i) begin
                        ld_a_o  = (opc == OP_LDA);
                        ld_b_o  = (opc == OP_LDB);
                        cnt_d   = '0;
                        state_d = S_FETCH;
                    end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
                        // Request is held through this last wait cycle, then abandoned.
                        mem_err_d = 1'b1;
                        cnt_d     = '0;
                        state_d   = S_FETCH;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        phase_o = 4'b0000;
        if (!rst_i) begin
            case (state_q)
                S_FETCH:  phase_o = 4'b0001;
                S_DECODE: phase_o = 4'b0010;
                S_EXEC:   phase_o = 4'b0100;
                S_MEM:    phase_o = 4'b1000;
                default:  phase_o = 4'b0000;
            endcase
        end
    end

    assign halted_o  = !rst_i && (state_q == S_HALT);
    assign mem_err_o = !rst_i && mem_err_q;

`ifdef SEQ_CTRL_PERF_CNT_EN
    logic [31:0] retired_q;

    always_ff @(posedge clk_i) begin
        if (rst_i)
            retired_q <= '0;
        else if (run_i && state_d == S_FETCH && (state_q == S_EXEC || state_q == S_MEM))
            retired_q <= retired_q + 32'd1;
    end

    assign retired_o = rst_i ? 32'd0 : retired_q;
`endif

endmodule

// File: tb/tb_seq_ctrl_unit.sv
// Directed bench for seq_ctrl_unit: per-cycle expected output vectors go through a scoreboard queue.
module tb_seq_ctrl_unit;

    typedef struct packed {
        logic [3:0] phase;
        logic       halted, mem_err, mem_req, mem_we;
        logic       ld_ir, inc_pc, ld_pc, ld_a, ld_b, ld_c, ld_z;
        logic       clr_a, clr_b, clr_c, clr_z;
        logic       a_mux, b_mux, im_mux1, reg_mux;
        logic [1:0] im_mux2, data_mux;
        logic [2:0] alu_op;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst, run, status_c, status_z, mem_ready;
    logic [31:0] inst;
    logic [3:0]  phase;
    logic        ld_ir, inc_pc, ld_pc, ld_a, ld_b, ld_c, ld_z;
    logic        clr_a, clr_b, clr_c, clr_z, a_mux, b_mux, im_mux1, reg_mux;
    logic [1:0]  im_mux2, data_mux;
    logic [2:0]  alu_op;
    logic        mem_req, mem_we, mem_err, halted;
`ifdef SEQ_CTRL_PERF_CNT_EN
    logic [31:0] retired;
`endif

    obs_t  obs;
    obs_t  exp_q[$];
    string tag_q[$];
    int    checks = 0;
    int    errors = 0;
    logic  err_exp = 1'b0;

    always #5 clk = ~clk;

    seq_ctrl_unit #(.INST_W(32), .OPC_W(4), .FUNC_W(4), .MEM_TIMEOUT(16)) dut (
        .clk_i(clk), .rst_i(rst), .run_i(run), .inst_i(inst),
        .status_c_i(status_c), .status_z_i(status_z), .mem_ready_i(mem_ready),
        .phase_o(phase), .ld_ir_o(ld_ir), .inc_pc_o(inc_pc), .ld_pc_o(ld_pc),
        .ld_a_o(ld_a), .ld_b_o(ld_b), .ld_c_o(ld_c), .ld_z_o(ld_z),
        .clr_a_o(clr_a), .clr_b_o(clr_b), .clr_c_o(clr_c), .clr_z_o(clr_z),
        .a_mux_o(a_mux), .b_mux_o(b_mux), .im_mux1_o(im_mux1), .reg_mux_o(reg_mux),
        .im_mux2_o(im_mux2), .data_mux_o(data_mux), .alu_op_o(alu_op),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_err_o(mem_err), .halted_o(halted)
`ifdef SEQ_CTRL_PERF_CNT_EN
        , .retired_o(retired)
`endif
    );

    assign obs = {phase, halted, mem_err, mem_req, mem_we, ld_ir, inc_pc, ld_pc,
                  ld_a, ld_b, ld_c, ld_z, clr_a, clr_b, clr_c, clr_z,
                  a_mux, b_mux, im_mux1, reg_mux, im_mux2, data_mux, alu_op};

    function automatic obs_t base(input logic [3:0] ph);
        obs_t e;
        e         = '0;
        e.phase   = ph;
        e.mem_err = err_exp;
        return e;
    endfunction

    // One clock: queue the expectation, compare at the falling edge, return just after the next rising edge.
    task automatic step(input string tag, input obs_t e);
        obs_t  got, ex;
        string t;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        ex  = exp_q.pop_front();
        t   = tag_q.pop_front();
        got = obs;
        checks++;
        assert (got === ex) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", t, got, ex);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input string tag, input logic [31:0] ins, input obs_t ex);
        obs_t e;
        inst = ins;
        e = base(4'b0001); e.ld_ir = 1'b1;
        step({tag, "_fetch"}, e);
        e = base(4'b0010); e.inc_pc = 1'b1; e.ld_pc = 1'b1;
        step({tag, "_decode"}, e);
        step({tag, "_exec"}, ex);
    endtask

    function automatic obs_t arith(input logic [2:0] op, input logic [1:0] im2);
        obs_t e;
        e = base(4'b0100);
        e.alu_op = op; e.im_mux2 = im2; e.data_mux = 2'b10;
        e.ld_a = 1'b1; e.ld_c = 1'b1; e.ld_z = 1'b1;
        return e;
    endfunction

    initial begin
        obs_t e;
        rst = 1'b1; run = 1'b1; inst = '0;
        status_c = 1'b0; status_z = 1'b0; mem_ready = 1'b0;
        step("reset0", '0);
        step("reset1", '0);
        rst = 1'b0;

        instr("add", 32'h7000_0000, arith(3'b010, 2'b00));

        // LDA: three wait cycles, ready on the fourth.
        e = base(4'b0100);
        instr("lda", 32'h9000_0000, e);
        for (int i = 0; i < 3; i++) begin
            e = base(4'b1000); e.mem_req = 1'b1; e.data_mux = 2'b01;
            step($sformatf("lda_wait%0d", i), e);
        end
        mem_ready = 1'b1;
        e = base(4'b1000); e.mem_req = 1'b1; e.data_mux = 2'b01; e.ld_a = 1'b1;
        step("lda_ready", e);
        mem_ready = 1'b0;

        e = base(4'b0100);
        instr("ldb", 32'hA000_0000, e);
        mem_ready = 1'b1;
        e = base(4'b1000); e.mem_req = 1'b1; e.data_mux = 2'b01; e.reg_mux = 1'b1; e.ld_b = 1'b1;
        step("ldb_ready", e);
        mem_ready = 1'b0;

        e = base(4'b0100);
        instr("stb", 32'h3000_0000, e);
        mem_ready = 1'b1;
        e = base(4'b1000); e.mem_req = 1'b1; e.mem_we = 1'b1; e.reg_mux = 1'b1;
        step("stb_ready", e);
        mem_ready = 1'b0;

        // STA with no ready: request held for exactly MEM_TIMEOUT cycles, then error.
        e = base(4'b0100);
        instr("sta", 32'h2000_0000, e);
        for (int i = 0; i < 16; i++) begin
            e = base(4'b1000); e.mem_req = 1'b1; e.mem_we = 1'b1;
            step($sformatf("sta_wait%0d", i), e);
        end
        err_exp = 1'b1;

        status_z = 1'b0;
        instr("beq_z0", 32'h6000_0000, base(4'b0100));
        status_z = 1'b1;
        e = base(4'b0100); e.ld_pc = 1'b1;
        instr("beq_z1", 32'h6000_0000, e);
        instr("bne_z1", 32'h8000_0000, base(4'b0100));
        status_z = 1'b0;
        e = base(4'b0100); e.ld_pc = 1'b1;
        instr("bne_z0", 32'h8000_0000, e);

        instr("addi", 32'h7100_0000, arith(3'b010, 2'b01));
        instr("deca", 32'h7E00_0000, arith(3'b011, 2'b10));
        instr("ori",  32'h7D00_0000, arith(3'b001, 2'b01));
        instr("ror",  32'h7F00_0000, arith(3'b101, 2'b00));
        e = base(4'b0100); e.clr_b = 1'b1;
        instr("clrb", 32'h7600_0000, e);
        status_c = 1'b1;
        e = base(4'b0100); e.inc_pc = 1'b1; e.ld_pc = 1'b1;
        instr("tstc_c1", 32'h7C00_0000, e);
        status_c = 1'b0;
        instr("tstz_z0", 32'h7A00_0000, base(4'b0100));
        e = base(4'b0100); e.im_mux1 = 1'b1; e.data_mux = 2'b01; e.alu_op = 3'b010;
        e.ld_a = 1'b1; e.ld_c = 1'b1; e.ld_z = 1'b1;
        instr("lui", 32'h4000_0000, e);
        e = base(4'b0100); e.ld_b = 1'b1; e.b_mux = 1'b1;
        instr("ldbi", 32'h1000_0000, e);
        e = base(4'b0100); e.ld_pc = 1'b1;
        instr("jmp", 32'h5000_0000, e);
        instr("undef", 32'hB000_0000, base(4'b0100));

        instr("halt", 32'hF000_0000, base(4'b0100));
        for (int i = 0; i < 20; i++) begin
            e = base(4'b0000); e.halted = 1'b1;
            step($sformatf("halted%0d", i), e);
        end
        rst = 1'b1;
        step("halt_rst", '0);
        rst = 1'b0;
        err_exp = 1'b0;

        // run=0 mid-MEM: ready is ignored while stalled, then the access completes.
        e = base(4'b0100);
        instr("stall_lda", 32'h9000_0000, e);
        e = base(4'b1000); e.mem_req = 1'b1; e.data_mux = 2'b01;
        step("stall_wait", e);
        run = 1'b0; mem_ready = 1'b1;
        for (int i = 0; i < 5; i++)
            step($sformatf("stall%0d", i), base(4'b1000));
        run = 1'b1; mem_ready = 1'b0;
        e = base(4'b1000); e.mem_req = 1'b1; e.data_mux = 2'b01;
        step("resume_wait", e);
        mem_ready = 1'b1;
        e = base(4'b1000); e.mem_req = 1'b1; e.data_mux = 2'b01; e.ld_a = 1'b1;
        step("resume_ready", e);
        mem_ready = 1'b0;
        e = base(4'b0001); e.ld_ir = 1'b1;
        step("after_stall_fetch", e);
`ifdef SEQ_CTRL_PERF_CNT_EN
        checks++;
        assert (retired === 32'd1) else begin
            errors++;
            $error("FAIL retired: observed %0d expected 1", retired);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
